shape_dispatcher: RTL and testbench

SHAPE_DISPATCHER -- requirements
Module: shape_dispatcher

---
 rtl/shape_dispatcher_if.sv | 22 ++
 rtl/shape_dispatcher.sv | 108 ++++++++++
 tb/tb_shape_dispatcher.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shape_dispatcher_if.sv
// Command and core-control bundle for the shape dispatcher.
// The master side is the host plus core control unit; the slave side is the dispatcher.
interface shape_dispatcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_shapeid;
  logic [95:0] cmd_coords;
  logic        newshape;
  logic [3:0]  shapeid;
  logic [95:0] coords;
  logic        shapedone;

  modport master (
    output cmd_valid, cmd_shapeid, cmd_coords, shapedone,
    input  cmd_ready, newshape, shapeid, coords
  );

  modport slave (
    input  cmd_valid, cmd_shapeid, cmd_coords, shapedone,
    output cmd_ready, newshape, shapeid, coords
  );
endinterface

// File: rtl/shape_dispatcher.sv
// Queues shape commands and hands them one at a time to the core control unit,
// retiring each on shapedone or on a 65535-cycle wait timeout.
module shape_dispatcher (
  input  logic                 clk,
  input  logic                 reset,
  shape_dispatcher_if.slave    bus,
  output logic                 busy,
  output logic                 badcmd,
  output logic                 timeout,
  output logic [15:0]          done_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAITDONE} state_t;

  state_t      state_reg, state_next;
  logic [99:0] mem [0:3];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  count_reg;
  logic        ready_en_reg;
  logic [3:0]  shapeid_reg;
  logic [95:0] coords_reg;
  logic [15:0] wait_cnt_reg;
  logic        badcmd_reg, timeout_reg;
  logic [15:0] done_count_reg;

  logic push_any, push_good, push_bad;
  logic pop, retire, expire, load;

  // The in-flight shape stays at the queue head until it retires, so it counts toward occupancy.
  assign bus.cmd_ready = ready_en_reg && (count_reg != 3'd4);
  assign push_any      = bus.cmd_valid && bus.cmd_ready;
  assign push_good     = push_any && (bus.cmd_shapeid <= 4'd2);
  assign push_bad      = push_any && (bus.cmd_shapeid > 4'd2);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    retire     = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != 3'd0) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAITDONE;
      end
      WAITDONE: begin
        if (bus.shapedone) begin
          pop        = 1'b1;
          retire     = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt_reg == 16'hFFFE) begin
          // Counter would reach 65535 on this edge: give up on the shape.
          pop        = 1'b1;
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load = (state_reg == IDLE) && (state_next == ISSUE);

  always_ff @(posedge clk) begin
    if (push_good) mem[wr_ptr_reg] <= {bus.cmd_shapeid, bus.cmd_coords};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= 2'd0;
      rd_ptr_reg     <= 2'd0;
      count_reg      <= 3'd0;
      ready_en_reg   <= 1'b0;
      shapeid_reg    <= 4'd0;
      coords_reg     <= 96'd0;
      wait_cnt_reg   <= 16'd0;
      badcmd_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      done_count_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      badcmd_reg   <= push_bad;
      if (push_good) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + {2'b00, push_good} - {2'b00, pop};
      if (load) begin
        shapeid_reg <= mem[rd_ptr_reg][99:96];
        coords_reg  <= mem[rd_ptr_reg][95:0];
      end
      if (state_reg == ISSUE)
        wait_cnt_reg <= 16'd0;
      else if (state_reg == WAITDONE)
        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      if (expire) timeout_reg <= 1'b1;
      if (retire) done_count_reg <= done_count_reg + 16'd1;
    end
  end

  assign bus.newshape = (state_reg == ISSUE);
  assign bus.shapeid  = shapeid_reg;
  assign bus.coords   = coords_reg;
  assign busy         = (state_reg != IDLE);
  assign badcmd       = badcmd_reg;
  assign timeout      = timeout_reg;
  assign done_count   = done_count_reg;
endmodule

// File: tb/tb_shape_dispatcher.sv
// Directed-sequence bench with randomized payloads; a queue-based model predicts
// issue order, retire counts and flag behaviour.
`timescale 1ns/1ps
module tb_shape_dispatcher;
  logic        clk = 1'b0;
  logic        reset;
  logic        busy, badcmd, timeout;
  logic [15:0] done_count;

  shape_dispatcher_if bus ();

  shape_dispatcher dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .badcmd(badcmd), .timeout(timeout), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ns_count = 0;
  logic [99:0] obs_q[$];
  logic [99:0] exp_q[$];
  int exp_done = 0;

  always @(negedge clk) begin
    if (bus.newshape) begin
      obs_q.push_back({bus.shapeid, bus.coords});
      ns_count++;
    end
  end

  task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic push(input logic [3:0] id, input logic [95:0] c);
    int guard = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_shapeid = id;
    bus.cmd_coords  = c;
    while (!bus.cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("push_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    if (id <= 4'd2) exp_q.push_back({id, c});
  endtask

  task automatic wait_waitdone();
    int guard = 0;
    while (!(busy && !bus.newshape) && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_waitdone", busy && !bus.newshape, 1);
  endtask

  task automatic serve(input bit more);
    wait_waitdone();
    tick($urandom_range(0, 4));
    bus.shapedone = 1'b1;
    tick();
    bus.shapedone = 1'b0;
    exp_done++;
    check("done_count", done_count, exp_done);
    check("idle_after_done", busy, 0);
    if (more) begin
      tick();
      check("reissue_d2", bus.newshape, 1);
    end
  endtask

  task automatic drain_compare(input string tag, input int expect_n);
    check({tag, "_count"}, obs_q.size(), expect_n);
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
  endtask

  initial begin
    logic [95:0] line_c;
    logic [3:0]  id5;
    logic [95:0] c5;
    int          snap;
    int          guard;

    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_shapeid = 4'd0;
    bus.cmd_coords  = 96'd0;
    bus.shapedone   = 1'b0;
    tick(2);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_newshape", bus.newshape, 0);
    check("rst_done_count", done_count, 0);
    reset = 1'b0;
    tick();
    check("ready_after_release", bus.cmd_ready, 1);

    // Single line, minimum latency and completion timing
    line_c = 96'h000A_0014_0064_00C8_0000_0000;
    push(4'd0, line_c);
    check("line_c1_newshape", bus.newshape, 0);
    tick();
    check("line_c2_newshape", bus.newshape, 1);
    check("line_shapeid", bus.shapeid, 0);
    check("line_coords", bus.coords, line_c);
    check("line_busy", busy, 1);
    tick(3);
    check("line_coords_held", bus.coords, line_c);
    tick(5);
    bus.shapedone = 1'b1;
    tick();
    bus.shapedone = 1'b0;
    exp_done++;
    check("line_done_count", done_count, exp_done);
    check("line_busy_after", busy, 0);
    drain_compare("line_order", 1);

    // Back-pressure with a stalled core
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 2)), rand96());
    check("bp_full_ready", bus.cmd_ready, 0);
    id5 = 4'($urandom_range(0, 2));
    c5  = rand96();
    bus.cmd_valid   = 1'b1;
    bus.cmd_shapeid = id5;
    bus.cmd_coords  = c5;
    tick(8);
    check("bp_stall_ready", bus.cmd_ready, 0);
    check("bp_stall_waitdone", busy && !bus.newshape, 1);
    bus.shapedone = 1'b1;
    check("bp_ready_pop_edge", bus.cmd_ready, 0);
    tick();
    bus.shapedone = 1'b0;
    exp_done++;
    check("bp_done_count", done_count, exp_done);
    check("bp_ready_after_pop", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    exp_q.push_back({id5, c5});
    check("bp_reissue_d2", bus.newshape, 1);
    serve(1); serve(1); serve(1); serve(0);
    drain_compare("bp_fifo_order", 5);

    // Rejected command
    tick(2);
    snap = ns_count;
    push(4'($urandom_range(3, 15)), rand96());
    check("bad_pulse", badcmd, 1);
    tick();
    check("bad_pulse_end", badcmd, 0);
    tick(5);
    check("bad_no_newshape", ns_count, snap);
    check("bad_not_busy", busy, 0);

    // Push and pop on the same edge at occupancy 2
    push(4'($urandom_range(0, 2)), rand96());
    push(4'($urandom_range(0, 2)), rand96());
    wait_waitdone();
    id5 = 4'($urandom_range(0, 2));
    c5  = rand96();
    bus.cmd_valid   = 1'b1;
    bus.cmd_shapeid = id5;
    bus.cmd_coords  = c5;
    bus.shapedone   = 1'b1;
    check("pp_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.shapedone = 1'b0;
    exp_q.push_back({id5, c5});
    exp_done++;
    check("pp_done_count", done_count, exp_done);
    push(4'($urandom_range(0, 2)), rand96());
    check("pp_occ3_ready", bus.cmd_ready, 1);
    push(4'($urandom_range(0, 2)), rand96());
    check("pp_occ4_ready", bus.cmd_ready, 0);
    serve(1); serve(1); serve(1); serve(0);
    drain_compare("pp_order", 5);

    // Reset in the middle of a shape with three more queued
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 2)), rand96());
    wait_waitdone();
    #3 reset = 1'b1;
    #1;
    check("mid_rst_newshape", bus.newshape, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_badcmd", badcmd, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_shapeid", bus.shapeid, 0);
    check("mid_rst_coords", bus.coords, 0);
    check("mid_rst_done_count", done_count, 0);
    check("mid_rst_ready", bus.cmd_ready, 0);
    drain_compare("pre_reset_order", 1);
    exp_q.delete();
    exp_done = 0;
    snap = ns_count;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(12);
    check("post_rst_no_newshape", ns_count, snap);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_done_count", done_count, 0);

    // Arc that never completes, then a queued shape behind it
    push(4'd2, rand96());
    push(4'($urandom_range(0, 2)), rand96());
    guard = 0;
    while (!bus.newshape && guard < 20) begin
      tick();
      guard++;
    end
    check("to_arc_issued", bus.newshape, 1);
    tick(65535);
    check("to_not_yet", timeout, 0);
    check("to_still_busy", busy, 1);
    tick();
    check("to_set", timeout, 1);
    check("to_busy_clear", busy, 0);
    check("to_done_count", done_count, 0);
    tick();
    check("to_next_issued", bus.newshape, 1);
    serve(0);
    check("to_sticky", timeout, 1);
    drain_compare("to_order", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
